// File: rtl/timing_multi.sv
// Sub-second tick generator, free-running tick count and NUM_CH run/pause/clear HMS timers.
// Optional lap capture registers are built when TIMING_LAP_EN is defined.
module timing_multi #(
  parameter int unsigned CLK_FREQ_HZ = 500000,
  parameter int unsigned TICK_HZ     = 2,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOUR_MAX    = 99,
  parameter int unsigned CUM_W       = 19
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       run,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       lap,
  output logic                    tick_pulse,
  output logic                    sec_pulse,
  output logic [CUM_W-1:0]        tick_cum,
  output logic [19*NUM_CH-1:0]    HMS_time,
  output logic [NUM_CH-1:0]       overflow,
  output logic [19*NUM_CH-1:0]    lap_time
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SUB_W = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(TICK_HZ - 1);
  localparam logic [6:0]       HOURS_LAST = 7'(HOUR_MAX);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             tick_q, tick_d;
  logic             sec_q, sec_d;
  logic [CUM_W-1:0] cum_q, cum_d;
  logic             strobe;

  logic [NUM_CH-1:0][18:0]      hms_q, hms_d;
  logic [NUM_CH-1:0][SUB_W-1:0] csub_q, csub_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d;
  logic [6:0]                   hrs;
  logic [5:0]                   mins;
  logic [5:0]                   secs;

  always_comb begin
    strobe = (pre_q == PRE_LAST);
    pre_d  = strobe ? '0 : pre_q + 1'b1;
    sub_d  = sub_q;
    sec_d  = 1'b0;
    if (strobe) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        sec_d = 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    tick_d = strobe;
    cum_d  = strobe ? cum_q + 1'b1 : cum_q;
  end

  // Channel sub-counter advances only on its own running strobes, so a pause keeps partial ticks.
  always_comb begin
    hms_d  = hms_q;
    csub_d = csub_q;
    ovf_d  = ovf_q;
    hrs    = '0;
    mins   = '0;
    secs   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      {hrs, mins, secs} = hms_q[c];
      if (clear[c]) begin
        hms_d[c]  = '0;
        csub_d[c] = '0;
        ovf_d[c]  = 1'b0;
      end else if (strobe && run[c] && !ovf_q[c]) begin
        if (csub_q[c] != SUB_LAST) begin
          csub_d[c] = csub_q[c] + 1'b1;
        end else begin
          csub_d[c] = '0;
          if (secs != 6'd59) begin
            secs = secs + 6'd1;
          end else begin
            secs = '0;
            if (mins != 6'd59) begin
              mins = mins + 6'd1;
            end else begin
              mins = '0;
              if (hrs != HOURS_LAST) begin
                hrs = hrs + 7'd1;
              end else begin
                // Saturate at the last representable time and freeze until cleared.
                hrs      = HOURS_LAST;
                mins     = 6'd59;
                secs     = 6'd59;
                ovf_d[c] = 1'b1;
              end
            end
          end
          hms_d[c] = {hrs, mins, secs};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      sub_q  <= '0;
      tick_q <= 1'b0;
      sec_q  <= 1'b0;
      cum_q  <= '0;
      hms_q  <= '0;
      csub_q <= '0;
      ovf_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      sub_q  <= sub_d;
      tick_q <= tick_d;
      sec_q  <= sec_d;
      cum_q  <= cum_d;
      hms_q  <= hms_d;
      csub_q <= csub_d;
      ovf_q  <= ovf_d;
    end
  end

  assign tick_pulse = tick_q;
  assign sec_pulse  = sec_q;
  assign tick_cum   = cum_q;
  assign HMS_time   = hms_q;
  assign overflow   = ovf_q;

`ifdef TIMING_LAP_EN
  logic [NUM_CH-1:0][18:0] lap_q, lap_d;

  // Captures the registered value, i.e. the time before any increment on the same edge.
  always_comb begin
    lap_d = lap_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (clear[c]) begin
        lap_d[c] = '0;
      end else if (lap[c]) begin
        lap_d[c] = hms_q[c];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap_time = lap_q;
`else
  logic unused_lap;
  assign unused_lap = ^lap;
  assign lap_time   = '0;
`endif

endmodule

// File: tb/tb_timing_multi.sv
// Randomised bench for timing_multi against a tick-count reference model
// (per-channel elapsed ticks converted to HMS by division).
module tb_timing_multi;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned TICK   = 2;
  localparam int unsigned NCH    = 2;
  localparam int unsigned HMAX   = 1;
  localparam int unsigned CW     = 8;
  localparam int unsigned DIV    = CLK_HZ / TICK;
  localparam int unsigned MAXSEC = HMAX * 3600 + 3599;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NCH-1:0]       run   = '0;
  logic [NCH-1:0]       clear = '0;
  logic [NCH-1:0]       lap   = '0;
  logic                 tick_pulse;
  logic                 sec_pulse;
  logic [CW-1:0]        tick_cum;
  logic [19*NCH-1:0]    HMS_time;
  logic [NCH-1:0]       overflow;
  logic [19*NCH-1:0]    lap_time;

  timing_multi #(
    .CLK_FREQ_HZ(CLK_HZ),
    .TICK_HZ    (TICK),
    .NUM_CH     (NCH),
    .HOUR_MAX   (HMAX),
    .CUM_W      (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .lap       (lap),
    .tick_pulse(tick_pulse),
    .sec_pulse (sec_pulse),
    .tick_cum  (tick_cum),
    .HMS_time  (HMS_time),
    .overflow  (overflow),
    .lap_time  (lap_time)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference model state
  int unsigned   cyc;
  int unsigned   tk[NCH];
  bit            ov[NCH];
  logic [18:0]   lapv[NCH];
  bit            m_stb, m_tick, m_sec;
  logic [CW-1:0] m_cum;

  function automatic logic [18:0] to_hms(input int unsigned ticks, input bit o);
    int unsigned s;
    s = o ? MAXSEC : ticks / TICK;
    return {7'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
  endfunction

  function automatic logic [19*NCH-1:0] exp_hms();
    logic [19*NCH-1:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) v[19*ch +: 19] = to_hms(tk[ch], ov[ch]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_ovf();
    logic [NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = ov[ch];
    return v;
  endfunction

  function automatic logic [19*NCH-1:0] exp_lap();
    logic [19*NCH-1:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) v[19*ch +: 19] = lapv[ch];
    return v;
  endfunction

  function automatic void model_reset();
    cyc = 0; m_stb = 0; m_tick = 0; m_sec = 0; m_cum = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      tk[ch] = 0; ov[ch] = 0; lapv[ch] = '0;
    end
  endfunction

  // Drive inputs (called just after an edge), take one rising edge, advance the model.
  task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] c, input logic [NCH-1:0] l);
    run = r; clear = c; lap = l;
    @(posedge clock);
    cyc++;
    m_stb  = (cyc % DIV == 0);
    m_tick = m_stb;
    m_sec  = m_stb && ((cyc / DIV) % TICK == 0);
    m_cum  = CW'(cyc / DIV);
    for (int ch = 0; ch < NCH; ch++) begin
      if (c[ch]) begin
        tk[ch] = 0; ov[ch] = 0; lapv[ch] = '0;
      end else begin
`ifdef TIMING_LAP_EN
        if (l[ch]) lapv[ch] = to_hms(tk[ch], ov[ch]);
`endif
        if (m_stb && r[ch] && !ov[ch]) begin
          tk[ch]++;
          if (tk[ch] / TICK > MAXSEC) ov[ch] = 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = NCH'($urandom); lap = NCH'($urandom);
    #7;
    vectors++; if (tick_pulse !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick_pulse); end
    vectors++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL reset_sec got=%b exp=0", sec_pulse); end
    vectors++; if (tick_cum !== '0) begin errors++; $display("FAIL reset_cum got=%0d exp=0", tick_cum); end
    vectors++; if (HMS_time !== '0) begin errors++; $display("FAIL reset_hms got=%h exp=0", HMS_time); end
    vectors++; if (overflow !== '0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    vectors++; if (lap_time !== '0) begin errors++; $display("FAIL reset_lap got=%h exp=0", lap_time); end
    reset = 1'b1;
    model_reset();
    for (int i = 1; i <= 3 * DIV * TICK; i++) begin
      step('0, '0, '0);
      vectors++;
      if (tick_pulse !== ((i % DIV) == 0)) begin
        errors++; $display("FAIL first_ticks edge=%0d got=%b exp=%b", i, tick_pulse, (i % DIV) == 0);
      end
      vectors++;
      if (sec_pulse !== ((i % (DIV * TICK)) == 0)) begin
        errors++; $display("FAIL first_secs edge=%0d got=%b exp=%b", i, sec_pulse, (i % (DIV * TICK)) == 0);
      end
      if (i == 3 * DIV) begin
        vectors++;
        if (tick_cum !== CW'(3)) begin errors++; $display("FAIL cum_after_3 got=%0d exp=3", tick_cum); end
      end
    end
  endtask

  task automatic test_run_122();
    int unsigned n;
    step('0, '1, '0);
    n = 0;
    while (n < 122) begin
      step(2'b01, '0, '0);
      if (m_stb) n++;
    end
    vectors++;
    if (HMS_time[18:0] !== {7'd0, 6'd1, 6'd1}) begin
      errors++; $display("FAIL run122_ch0 got=%h exp=%h", HMS_time[18:0], {7'd0, 6'd1, 6'd1});
    end
    vectors++;
    if (HMS_time[37:19] !== 19'd0) begin errors++; $display("FAIL run122_ch1 got=%h exp=0", HMS_time[37:19]); end
    vectors++;
    if (HMS_time !== exp_hms()) begin errors++; $display("FAIL run122_model got=%h exp=%h", HMS_time, exp_hms()); end
  endtask

  task automatic test_pause();
    int unsigned n;
    step('0, 2'b01, '0);
    n = 0;
    while (n < 1) begin step(2'b01, '0, '0); if (m_stb) n++; end
    for (int i = 0; i < 3 * DIV; i++) step('0, '0, '0);
    vectors++;
    if (HMS_time[18:0] !== 19'd0) begin errors++; $display("FAIL pause_hold got=%h exp=0", HMS_time[18:0]); end
    n = 0;
    while (n < 1) begin step(2'b01, '0, '0); if (m_stb) n++; end
    vectors++;
    if (HMS_time[18:0] !== 19'd1) begin errors++; $display("FAIL pause_resume got=%h exp=1", HMS_time[18:0]); end
  endtask

  task automatic test_clear_strobe();
    int unsigned n;
    step('0, 2'b01, '0);
    n = 0;
    while (n < TICK + 1) begin step(2'b01, '0, '0); if (m_stb) n++; end
    while ((cyc + 1) % DIV != 0) step(2'b01, '0, '0);
    vectors++;
    if (HMS_time[18:0] !== 19'd1) begin errors++; $display("FAIL pre_clear got=%h exp=1", HMS_time[18:0]); end
    step(2'b01, 2'b01, '0);
    vectors++;
    if (tick_pulse !== 1'b1) begin errors++; $display("FAIL clr_strobe_tick got=%b exp=1", tick_pulse); end
    vectors++;
    if (HMS_time[18:0] !== 19'd0) begin errors++; $display("FAIL clr_strobe_hms got=%h exp=0", HMS_time[18:0]); end
  endtask

  task automatic test_lap();
    int unsigned n;
    logic [18:0] exp_l;
    step('0, 2'b01, '0);
    n = 0;
    while (n < 5 * TICK + 1) begin step(2'b01, '0, '0); if (m_stb) n++; end
    while ((cyc + 1) % DIV != 0) step(2'b01, '0, '0);
    step(2'b01, '0, 2'b01);
`ifdef TIMING_LAP_EN
    exp_l = {7'd0, 6'd0, 6'd5};
`else
    exp_l = '0;
`endif
    vectors++;
    if (lap_time[18:0] !== exp_l) begin errors++; $display("FAIL lap_capture got=%h exp=%h", lap_time[18:0], exp_l); end
    vectors++;
    if (HMS_time[18:0] !== {7'd0, 6'd0, 6'd6}) begin
      errors++; $display("FAIL lap_continue got=%h exp=%h", HMS_time[18:0], {7'd0, 6'd0, 6'd6});
    end
    step(2'b01, 2'b01, 2'b01);
    vectors++;
    if (lap_time[18:0] !== 19'd0) begin errors++; $display("FAIL lap_clear_prio got=%h exp=0", lap_time[18:0]); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] r, c, l;
    for (int i = 0; i < 1500; i++) begin
      r = NCH'($urandom);
      for (int ch = 0; ch < NCH; ch++) begin
        c[ch] = ($urandom_range(15) == 0);
        l[ch] = ($urandom_range(7) == 0);
      end
      step(r, c, l);
      vectors++; if (tick_pulse !== m_tick) begin errors++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", cyc, tick_pulse, m_tick); end
      vectors++; if (sec_pulse !== m_sec) begin errors++; $display("FAIL rand_sec cyc=%0d got=%b exp=%b", cyc, sec_pulse, m_sec); end
      vectors++; if (tick_cum !== m_cum) begin errors++; $display("FAIL rand_cum cyc=%0d got=%0d exp=%0d", cyc, tick_cum, m_cum); end
      vectors++; if (HMS_time !== exp_hms()) begin errors++; $display("FAIL rand_hms cyc=%0d got=%h exp=%h", cyc, HMS_time, exp_hms()); end
      vectors++; if (overflow !== exp_ovf()) begin errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf()); end
      vectors++; if (lap_time !== exp_lap()) begin errors++; $display("FAIL rand_lap cyc=%0d got=%h exp=%h", cyc, lap_time, exp_lap()); end
    end
  endtask

  task automatic test_overflow();
    int unsigned n, extra;
    logic [NCH-1:0] r;
    step('0, '1, '0);
    n = 0; extra = 0;
    while (extra < 2 && n < (MAXSEC + 4) * TICK) begin
      r = {1'($urandom), 1'b1};
      if (ov[0] && m_stb) extra++;
      step(r, '0, '0);
      if (m_stb) n++;
      vectors++; if (HMS_time !== exp_hms()) begin errors++; $display("FAIL ovf_hms cyc=%0d got=%h exp=%h", cyc, HMS_time, exp_hms()); end
      vectors++; if (overflow !== exp_ovf()) begin errors++; $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf()); end
      vectors++; if (tick_cum !== m_cum) begin errors++; $display("FAIL ovf_cum cyc=%0d got=%0d exp=%0d", cyc, tick_cum, m_cum); end
      vectors++; if (sec_pulse !== m_sec) begin errors++; $display("FAIL ovf_sec cyc=%0d got=%b exp=%b", cyc, sec_pulse, m_sec); end
    end
    vectors++;
    if (HMS_time[18:0] !== {7'(HMAX), 6'd59, 6'd59}) begin
      errors++; $display("FAIL sat_value got=%h exp=%h", HMS_time[18:0], {7'(HMAX), 6'd59, 6'd59});
    end
    vectors++;
    if (overflow[0] !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", overflow[0]); end
    step(2'b01, 2'b01, '0);
    vectors++;
    if (overflow[0] !== 1'b0) begin errors++; $display("FAIL sat_clear_flag got=%b exp=0", overflow[0]); end
    n = 0;
    while (n < 2 * TICK) begin step(2'b01, '0, '0); if (m_stb) n++; end
    vectors++;
    if (HMS_time[18:0] !== 19'd2) begin errors++; $display("FAIL sat_recount got=%h exp=2", HMS_time[18:0]); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) step(2'b11, '0, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (tick_cum !== '0) begin errors++; $display("FAIL areset_cum got=%0d exp=0", tick_cum); end
    vectors++; if (HMS_time !== '0) begin errors++; $display("FAIL areset_hms got=%h exp=0", HMS_time); end
    vectors++; if (lap_time !== '0) begin errors++; $display("FAIL areset_lap got=%h exp=0", lap_time); end
    vectors++; if ({tick_pulse, sec_pulse, overflow} !== '0) begin
      errors++; $display("FAIL areset_flags got=%b exp=0", {tick_pulse, sec_pulse, overflow});
    end
    reset = 1'b1;
    model_reset();
    for (int i = 1; i <= DIV; i++) begin
      step('0, '0, '0);
      vectors++;
      if (tick_pulse !== (i == DIV)) begin errors++; $display("FAIL areset_first edge=%0d got=%b exp=%b", i, tick_pulse, i == DIV); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_122();
    test_pause();
    test_clear_strobe();
    test_lap();
    test_random();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/timing_multi.md
Name: timing_multi

Overview:
- Parametrised successor of the single-channel `timing` block.
- Generates a configurable sub-second tick from the system clock and keeps a free-running cumulative tick count.
- Runs NUM_CH independent run/pause/clear HMS timers, e.g. ride time, trip time and total time in the bike computer.
- Feeds the display mux and the speed/distance logic, which consume tick_pulse as their time base.

Parameters:
- CLK_FREQ_HZ, 500000, system clock frequency in Hz.
- TICK_HZ, 2, tick rate in Hz. DIV = CLK_FREQ_HZ/TICK_HZ must be an integer >= 2.
- NUM_CH, 2, number of independent HMS timers (1..8).
- HOUR_MAX, 99, highest hours value; must fit in 7 bits.
- CUM_W, 19, width of the cumulative tick counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  NUM_CH  per-channel level; 1 = channel counts ticks.
- clear  in  NUM_CH  per-channel synchronous clear pulse.
- lap  in  NUM_CH  per-channel lap capture pulse (used only with TIMING_LAP_EN).
- tick_pulse  out  1  one-cycle pulse at TICK_HZ.
- sec_pulse  out  1  one-cycle pulse once per second, coincident with every TICK_HZ-th tick_pulse.
- tick_cum  out  CUM_W  free-running tick count.
- HMS_time  out  19*NUM_CH  per channel {hours[6:0], minutes[5:0], seconds[5:0]}; channel 0 in bits [18:0].
- overflow  out  NUM_CH  sticky per-channel saturation flag.
- lap_time  out  19*NUM_CH  captured HMS per channel (only with TIMING_LAP_EN).

Behaviour:
- Reset (reset=0, asynchronous): all counters, all outputs and all lap registers go to 0. Release is sampled synchronously; first tick_pulse occurs DIV cycles after the first clock edge with reset=1.
- Prescaler:
  - pre counts 0..DIV-1 and wraps to 0.
  - Internal strobe = (pre==DIV-1).
  - tick_pulse is registered: it is high for exactly the one cycle following the strobe edge.
- Second divider: sub counts strobes 0..TICK_HZ-1. sec_pulse is registered and asserts together with tick_pulse when sub wraps.
- tick_cum increments on every strobe and wraps modulo 2^CUM_W with no flag.
- Channel c, evaluated on each clock edge in priority order:
  1. clear[c]=1: HMS, channel sub-counter, overflow[c] and lap_time[c] go to 0. Any simultaneous strobe is discarded. clear works whether run is 0 or 1.
  2. Else if strobe and run[c]=1 and overflow[c]=0: increment the channel sub-counter.
     - On reaching TICK_HZ, the sub-counter goes to 0 and seconds increments.
     - Seconds 59 wraps to 0 and carries into minutes.
     - Minutes 59 wraps to 0 and carries into hours.
     - If hours==HOUR_MAX and a carry arrives: HMS holds at HOUR_MAX:59:59, overflow[c] is set, and counting stops until clear.
  3. Else hold.
- HMS_time changes on the same edge as the tick_pulse rising; no extra latency.
- run[c] 1->0 pauses the channel and keeps its sub-counter, so partial ticks are not lost. The channel sub-counter is independent of the global sub and prescaler phase.
- Channels share the prescaler. A run change between strobes has no effect until the next strobe.
- Unused inputs (lap without the macro) are ignored.

Optional Feature:
- Macro: TIMING_LAP_EN.
- Defined:
  - lap[c]=1 copies the current HMS_time[c] into lap_time[c] on that edge.
  - If a strobe increments on the same edge, the pre-increment value is captured.
  - clear has priority over lap.
- Undefined: no lap registers are built; lap_time is tied to 0 and lap is unused.

Test Plan:
- CLK_FREQ_HZ=8, TICK_HZ=2 (DIV=4). Release reset -> tick_pulse high on cycles 4, 8, 12…; sec_pulse on cycles 8, 16…; tick_cum=3 after cycle 12.
- run[0]=1 for 122 ticks -> HMS_time[0] = 0:01:01; channel 1 with run=0 stays 0.
- Preload to HOUR_MAX:59:59 by forcing the count, apply 2 more ticks -> holds 99:59:59, overflow[0]=1. Then clear[0] -> all 0, overflow=0, next ticks count from 0.
- Pause with run[0]=0 after 1 tick (sub=1), resume -> seconds increments after exactly 1 further tick.
- clear[0] and strobe on the same cycle -> HMS_time[0]=0. reset asserted mid-count, asynchronously between edges -> all outputs 0 immediately.
- TIMING_LAP_EN: lap[0] at 0:00:05 coinciding with a strobe -> lap_time[0]=0:00:05 while HMS_time[0] continues counting.
